// File: rtl/video_pll_reset_sequencer_if.sv
// Signal bundle between the video PLL reset sequencer and its environment.
// The slave modport is the sequencer's view. The master modport is the view of
// whatever drives lock, enables and clear, and watches the resets.
//   locked          - raw PLL lock, asynchronous to refclk
//   chan_enable     - per-channel enable mask
//   clear           - single-cycle clear of timeout and lock_loss_count
//   pll_rst         - PLL reset, active-high
//   chan_rst        - per-channel reset, active-high, registered
//   ready           - all enabled channels released and lock held
//   lock_loss_count - saturating count of lock losses
//   timeout         - sticky lock-timeout flag
interface video_pll_reset_sequencer_if #(
  parameter int NUM_CLOCKS = 3,
  parameter int CNT_WIDTH  = 8
);
  logic                  locked;
  logic [NUM_CLOCKS-1:0] chan_enable;
  logic                  clear;
  logic                  pll_rst;
  logic [NUM_CLOCKS-1:0] chan_rst;
  logic                  ready;
  logic [CNT_WIDTH-1:0]  lock_loss_count;
  logic                  timeout;

  modport master (
    output locked, chan_enable, clear,
    input  pll_rst, chan_rst, ready, lock_loss_count, timeout
  );

  modport slave (
    input  locked, chan_enable, clear,
    output pll_rst, chan_rst, ready, lock_loss_count, timeout
  );
endinterface

// File: rtl/video_pll_reset_sequencer.sv
// Reset and lock supervisor for the video PLL, clocked by the PLL reference clock.
// It pulses the PLL reset and filters the synchronised lock. It then releases the
// channel resets one by one in a staggered order. On loss of lock it drops back
// to a fresh PLL reset and counts the event.
// Ports:
//   refclk - sole clock
//   rst    - synchronous active-high reset
//   bus    - slave modport of video_pll_reset_sequencer_if (lock in, enables,
//            clear, pll_rst / chan_rst / ready / lock_loss_count / timeout out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RESET | pll_rst held high for PLL_RST_CYCLES cycles
// WAIT_LOCK | filter lock; retry the PLL reset after RELOCK_TIMEOUT_CYCLES
// RELEASE   | release one channel every STAGGER_CYCLES cycles
// RUN       | channels follow chan_enable, ready high
module video_pll_reset_sequencer #(
  parameter int NUM_CLOCKS            = 3,
  parameter int PLL_RST_CYCLES        = 8,
  parameter int LOCK_FILTER_CYCLES    = 1024,
  parameter int STAGGER_CYCLES        = 16,
  parameter int RELOCK_TIMEOUT_CYCLES = 1048576,
  parameter int CNT_WIDTH             = 8
) (
  input logic refclk,
  input logic rst,
  video_pll_reset_sequencer_if.slave bus
);

  localparam int RW = $clog2(PLL_RST_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int TW = $clog2(RELOCK_TIMEOUT_CYCLES + 1);
  localparam int KW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

  // Timers are down-counters loaded with (length - 1). Terminal count is zero.
  localparam logic [RW-1:0] RST_LOAD  = RW'(PLL_RST_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LOAD = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LOAD = SW'(STAGGER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(RELOCK_TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_CLOCKS - 1);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  locked_m, locked_s;
  logic [RW-1:0]         rst_cnt, rst_cnt_nxt;
  logic [FW-1:0]         filt_cnt, filt_cnt_nxt;
  logic [TW-1:0]         tmo_cnt, tmo_cnt_nxt;
  logic [SW-1:0]         stag_cnt, stag_cnt_nxt;
  logic [KW-1:0]         chan_idx, chan_idx_nxt;
  logic [NUM_CLOCKS-1:0] chan_rst_q, chan_rst_nxt;
  logic                  pll_rst_q, ready_q;
  logic                  timeout_q, timeout_nxt;
  logic [CNT_WIDTH-1:0]  loss_cnt_q, loss_cnt_nxt;
  logic                  lock_lost, timed_out;

  always_comb begin
    state_nxt    = state;
    rst_cnt_nxt  = rst_cnt;
    filt_cnt_nxt = filt_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    stag_cnt_nxt = stag_cnt;
    chan_idx_nxt = chan_idx;
    chan_rst_nxt = chan_rst_q;
    lock_lost    = 1'b0;
    timed_out    = 1'b0;

    case (state)
      PLL_RESET: begin
        if (rst_cnt == '0) begin
          state_nxt    = WAIT_LOCK;
          filt_cnt_nxt = FILT_LOAD;
          tmo_cnt_nxt  = TMO_LOAD;
        end else begin
          rst_cnt_nxt = rst_cnt - 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (locked_s) begin
          if (filt_cnt == '0) begin
            state_nxt    = RELEASE;
            stag_cnt_nxt = STAG_LOAD;
            chan_idx_nxt = '0;
          end else begin
            filt_cnt_nxt = filt_cnt - 1'b1;
          end
        end else begin
          filt_cnt_nxt = FILT_LOAD;
        end
        // Lock acceptance wins if it coincides with the timeout expiring.
        if (state_nxt == WAIT_LOCK) begin
          if (tmo_cnt == '0) begin
            timed_out   = 1'b1;
            state_nxt   = PLL_RESET;
            rst_cnt_nxt = RST_LOAD;
          end else begin
            tmo_cnt_nxt = tmo_cnt - 1'b1;
          end
        end
      end

      RELEASE: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (stag_cnt == '0) begin
          // A disabled channel still uses its slot; it just stays in reset.
          chan_rst_nxt[chan_idx] = ~bus.chan_enable[chan_idx];
          stag_cnt_nxt           = STAG_LOAD;
          if (chan_idx == K_LAST) begin
            state_nxt = RUN;
          end else begin
            chan_idx_nxt = chan_idx + 1'b1;
          end
        end else begin
          stag_cnt_nxt = stag_cnt - 1'b1;
        end
      end

      RUN: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else begin
          chan_rst_nxt = ~bus.chan_enable;
        end
      end

      default: state_nxt = PLL_RESET;
    endcase

    if (lock_lost) begin
      state_nxt   = PLL_RESET;
      rst_cnt_nxt = RST_LOAD;
    end

    if (state_nxt == PLL_RESET || state_nxt == WAIT_LOCK) begin
      chan_rst_nxt = '1;
    end

    // clear takes priority over a coincident timeout or lock loss
    timeout_nxt = timeout_q;
    if (bus.clear) begin
      timeout_nxt = 1'b0;
    end else if (timed_out) begin
      timeout_nxt = 1'b1;
    end

    loss_cnt_nxt = loss_cnt_q;
    if (bus.clear) begin
      loss_cnt_nxt = '0;
    end else if (lock_lost && loss_cnt_q != '1) begin
      loss_cnt_nxt = loss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= PLL_RESET;
      locked_m   <= 1'b0;
      locked_s   <= 1'b0;
      rst_cnt    <= RST_LOAD;
      filt_cnt   <= '0;
      tmo_cnt    <= '0;
      stag_cnt   <= '0;
      chan_idx   <= '0;
      chan_rst_q <= '1;
      pll_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      locked_m   <= bus.locked;
      locked_s   <= locked_m;
      state      <= state_nxt;
      rst_cnt    <= rst_cnt_nxt;
      filt_cnt   <= filt_cnt_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      stag_cnt   <= stag_cnt_nxt;
      chan_idx   <= chan_idx_nxt;
      chan_rst_q <= chan_rst_nxt;
      pll_rst_q  <= (state_nxt == PLL_RESET);
      ready_q    <= (state_nxt == RUN);
      timeout_q  <= timeout_nxt;
      loss_cnt_q <= loss_cnt_nxt;
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.chan_rst        = chan_rst_q;
  assign bus.ready           = ready_q;
  assign bus.timeout         = timeout_q;
  assign bus.lock_loss_count = loss_cnt_q;

endmodule
